median_window_ctrl: RTL and testbench
=====================================

Name: median_window_ctrl

Overview:
Frame-level controller for the 3x3 median filter datapath. Accepts a raster pixel stream one pixel per cycle and keeps two line buffers. Drives the filter's three row inputs (oldest row on d1, newest on d3) and tags which filter outputs are full interior windows. Reports per-frame completion and stream-protocol errors. Sits between the pixel source and the median filter instance, and re-emits the filter result with a valid strobe.

Parameters:
IMG_W, 640, pixels per row (>=3)
IMG_H, 480, rows per frame (>=3)
DW, 8, pixel width
PIPE_LAT, 4, cycles from row outputs changing to the matching median on med_i; set to match the filter instance

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start_i  in  1  begin a frame; sampled only in IDLE
pix_valid_i  in  1  pixel present on pix_i
pix_i  in  DW  input pixel, raster order
ready_o  out  1  controller accepts pixels; accept = pix_valid_i & ready_o
busy_o  out  1  state != IDLE
row0_o  out  DW  to filter d1 (row r-2)
row1_o  out  DW  to filter d2 (row r-1)
row2_o  out  DW  to filter d3 (row r, current pixel)
med_i  in  DW  filter median output
med_valid_o  out  1  med_o holds an interior-window median
med_o  out  DW  registered copy of med_i
frame_done_o  out  1  one-cycle pulse at end of frame
err_o  out  1  sticky protocol error

Behaviour:
- Reset: state IDLE; all outputs 0; col/row counters 0; valid-tag shift register cleared. Line-buffer RAM contents are not cleared (FILL rewrites them).
- States:
  - IDLE: start_i -> FILL; err_o cleared on that same edge.
  - FILL: covers rows 0-1. Line buffers are written; no valid tags.
  - RUN: covers rows 2..IMG_H-1.
  - FLUSH: entered after the last pixel (r=IMG_H-1, c=IMG_W-1) is accepted.
  - DONE: one cycle; pulses frame_done_o, then -> IDLE.
- ready_o = 1 in FILL and RUN only. start_i is ignored outside IDLE.
- Per accepted pixel at column c:
  - row2_o <= pix_i; row1_o <= lb1[c]; row0_o <= lb0[c].
  - Then write lb0[c] <= lb1[c] and lb1[c] <= pix_i.
  - Row outputs are registered and update 1 cycle after accept; otherwise they hold.
- Counters:
  - col wraps IMG_W-1 -> 0 and increments row.
  - FILL -> RUN when row wraps 1 -> 2.
  - Counter widths are $clog2 of IMG_W and IMG_H.
- Valid tag:
  - tag = accept & (row>=2) & (col>=2).
  - Tag passes through a (1+PIPE_LAT)-stage shift register that shifts every cycle.
  - med_o <= med_i every cycle; med_valid_o <= shifted tag.
  - A pixel accepted at cycle t yields med_valid_o at t+2+PIPE_LAT.
  - Exactly (IMG_W-2)*(IMG_H-2) strobes per frame; border windows produce no strobes.
- FLUSH: counts PIPE_LAT+2 cycles so the last strobe has been emitted, then -> DONE.
- Protocol rules:
  - Within a row (col != 0), pix_valid_i must stay high on every cycle, because the filter shifts every clock.
  - A gap at col != 0 in FILL or RUN sets err_o and sends the controller to IDLE next cycle. No frame_done_o is issued.
  - Tags already in flight still emerge.
  - Gaps at col==0 (between rows, or before the first pixel) are legal.
- rst mid-frame: immediate return to reset values; in-flight tags are discarded.

Optional Feature:
MEDIAN_FRAME_CNT_EN
- Defined: adds output frame_cnt_o [15:0], reset 0. It increments on each frame_done_o and wraps 0xFFFF -> 0. Aborted frames do not count.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- IMG_W=8, IMG_H=6, PIPE_LAT=4; start, then 48 pixels back-to-back with value = index -> exactly 24 med_valid_o strobes. The first strobe comes 6 cycles after pixel 18 (r2,c2) is accepted. frame_done_o pulses once, then busy_o=0.
- Constant 0x55 frame with one 0xFF impulse at (3,3) -> every med_o strobe = 0x55.
- Insert 2-cycle pix_valid_i gaps only at col 0 of every row -> the same 24 strobes and values as scenario 1, with no err_o.
- Drop pix_valid_i at (r3,c4) -> err_o=1 and busy_o=0 the next cycle, no frame_done_o. A later start_i clears err_o and the full frame completes normally.
- Assert rst at pixel 30, then run a full frame -> no stale strobes, 24 correct strobes.
- With MEDIAN_FRAME_CNT_EN: 3 frames back-to-back -> frame_cnt_o = 1, 2, 3; an aborted frame leaves it unchanged.

Source files
------------

// File: rtl/median_window_ctrl.sv
// Frame controller for a 3x3 median filter: line buffers, row feeds, interior-window tagging.
// Optional MEDIAN_FRAME_CNT_EN adds a 16-bit completed-frame counter output.
//
// state | meaning
// IDLE  | waiting for start_i
// FILL  | rows 0-1, priming the line buffers
// RUN   | rows 2..IMG_H-1, interior windows are tagged
// FLUSH | last pixel taken, draining the filter pipeline
// DONE  | one-cycle frame_done_o pulse
module median_window_ctrl #(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int DW       = 8,
  parameter int PIPE_LAT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          pix_valid_i,
  input  logic [DW-1:0] pix_i,
  output logic          ready_o,
  output logic          busy_o,
  output logic [DW-1:0] row0_o,
  output logic [DW-1:0] row1_o,
  output logic [DW-1:0] row2_o,
  input  logic [DW-1:0] med_i,
  output logic          med_valid_o,
  output logic [DW-1:0] med_o,
  output logic          frame_done_o,
  output logic          err_o
`ifdef MEDIAN_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt_o
`endif
);

  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);
  localparam int SRL = PIPE_LAT + 1;
  localparam int FW  = $clog2(PIPE_LAT + 2) + 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    RUN   = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [FW-1:0]    flush_q, flush_d;
  logic [SRL-1:0]   tag_sr_q, tag_sr_d;
  logic [DW-1:0]    row0_q, row0_d, row1_q, row1_d, row2_q, row2_d;
  logic [DW-1:0]    med_q, med_d;
  logic             med_valid_q, med_valid_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             accept, gap, tag;

  logic [DW-1:0]    lb0_q [IMG_W];
  logic [DW-1:0]    lb1_q [IMG_W];

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    flush_d     = flush_q;
    row0_d      = row0_q;
    row1_d      = row1_q;
    row2_d      = row2_q;
    err_d       = err_q;
    done_d      = 1'b0;
    med_d       = med_i;
    med_valid_d = tag_sr_q[SRL-1];

    accept   = pix_valid_i & ready_q;
    // The filter shifts every clock, so a missing pixel mid-row corrupts its window.
    gap      = ready_q & ~pix_valid_i & (col_q != '0);
    tag      = accept & (row_q >= ROW_TWO) & (col_q >= COL_TWO);
    tag_sr_d = (tag_sr_q << 1) | SRL'(tag);

    if (accept) begin
      row2_d = pix_i;
      row1_d = lb1_q[col_q];
      row0_d = lb0_q[col_q];
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = FILL;
          err_d   = 1'b0;
          col_d   = '0;
          row_d   = '0;
        end
      end
      FILL, RUN: begin
        if (gap) begin
          state_d = IDLE;
          err_d   = 1'b1;
          col_d   = '0;
          row_d   = '0;
        end else if (accept) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              state_d = FLUSH;
              flush_d = FW'(PIPE_LAT + 1);
            end else begin
              row_d = row_q + 1'b1;
              if (row_q == ROW_ONE) state_d = RUN;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (flush_q == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          flush_d = flush_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == FILL) || (state_d == RUN);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      flush_q     <= '0;
      tag_sr_q    <= '0;
      row0_q      <= '0;
      row1_q      <= '0;
      row2_q      <= '0;
      med_q       <= '0;
      med_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      flush_q     <= flush_d;
      tag_sr_q    <= tag_sr_d;
      row0_q      <= row0_d;
      row1_q      <= row1_d;
      row2_q      <= row2_d;
      med_q       <= med_d;
      med_valid_q <= med_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  // Line buffers are plain storage; FILL rewrites every entry before it is consumed.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0_q[col_q] <= lb1_q[col_q];
      lb1_q[col_q] <= pix_i;
    end
  end

  assign ready_o      = ready_q;
  assign busy_o       = busy_q;
  assign row0_o       = row0_q;
  assign row1_o       = row1_q;
  assign row2_o       = row2_q;
  assign med_o        = med_q;
  assign med_valid_o  = med_valid_q;
  assign frame_done_o = done_q;
  assign err_o        = err_q;

`ifdef MEDIAN_FRAME_CNT_EN
  logic [15:0] fcnt_q, fcnt_d;

  always_comb fcnt_d = fcnt_q + 16'(done_q);

  always_ff @(posedge clk) begin
    if (rst) fcnt_q <= '0;
    else     fcnt_q <= fcnt_d;
  end

  assign frame_cnt_o = fcnt_q;
`endif

endmodule

// File: tb/tb_median_window_ctrl.sv
// Self-checking bench for median_window_ctrl: image-level median model plus a behavioural filter.
// Build with MEDIAN_FRAME_CNT_EN defined to also check the frame counter.
module tb_median_window_ctrl;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int P  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst, start_i, pix_valid_i;
  logic [DW-1:0] pix_i, med_i;
  logic          ready_o, busy_o, med_valid_o, frame_done_o, err_o;
  logic [DW-1:0] row0_o, row1_o, row2_o, med_o;
`ifdef MEDIAN_FRAME_CNT_EN
  logic [15:0]   frame_cnt_o;
`endif

  always #5 clk = ~clk;

  median_window_ctrl #(.IMG_W(W), .IMG_H(H), .DW(DW), .PIPE_LAT(P)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .pix_valid_i(pix_valid_i), .pix_i(pix_i),
    .ready_o(ready_o), .busy_o(busy_o), .row0_o(row0_o), .row1_o(row1_o), .row2_o(row2_o),
    .med_i(med_i), .med_valid_o(med_valid_o), .med_o(med_o), .frame_done_o(frame_done_o),
    .err_o(err_o)
`ifdef MEDIAN_FRAME_CNT_EN
    , .frame_cnt_o(frame_cnt_o)
`endif
  );

  typedef struct { int val; int due; } exp_t;
  typedef struct { int pat; int gap; int strobes; int err; } vec_t;

  exp_t          exp_q[$];
  logic [DW-1:0] h0[$], h1[$], h2[$];
  logic [DW-1:0] img[H][W];
  int n_vec = 0, n_bad = 0;
  int cyc = 0;
  int done_cnt = 0, done_cyc = 0, strobe_cnt = 0;
  int last_acc = 0, acc18 = 0, first_strobe = -1;
  int exp_frames = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int act, int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int med9(int v[9]);
    int t;
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
    return v[4];
  endfunction

  function automatic int win_med(int r, int c);
    int v[9];
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) v[i*3+j] = int'(img[r-2+i][c-2+j]);
    return med9(v);
  endfunction

  // Behavioural 3x3 median filter fed by the row outputs, plus the strobe monitor.
  initial begin
    int v[9];
    exp_t e;
    med_i = '0;
    forever begin
      @(negedge clk);
      if (med_valid_o) begin
        strobe_cnt++;
        if (first_strobe < 0) first_strobe = cyc;
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL stray_strobe: med_o=%0d at cycle %0d, no strobe expected", med_o, cyc);
        end else begin
          e = exp_q.pop_front();
          check("strobe_val", int'(med_o), e.val);
          check("strobe_cycle", cyc, e.due);
        end
      end
      if (frame_done_o) begin done_cnt++; done_cyc = cyc; end
      h0.push_back(row0_o); h1.push_back(row1_o); h2.push_back(row2_o);
      if (h0.size() > P + 3) begin void'(h0.pop_front()); void'(h1.pop_front()); void'(h2.pop_front()); end
      if (h0.size() == P + 3) begin
        for (int j = 0; j < 3; j++) begin
          v[j] = int'(h0[j]); v[3+j] = int'(h1[j]); v[6+j] = int'(h2[j]);
        end
        med_i = DW'(med9(v));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic fill_img(int pat);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (pat)
          0:       img[r][c] = DW'(r*W + c);
          1:       img[r][c] = (r == 3 && c == 3) ? 8'hFF : 8'h55;
          default: img[r][c] = DW'($urandom_range(255, 0));
        endcase
  endtask

  task automatic drive_pix(int r, int c);
    pix_valid_i = 1'b1;
    pix_i = img[r][c];
    if (r >= 2 && c >= 2) exp_q.push_back('{val: win_med(r, c), due: cyc + 2 + P});
    if (r == 2 && c == 2) acc18 = cyc;
    last_acc = cyc;
    step();
    pix_valid_i = 1'b0;
  endtask

  task automatic start_frame();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic finish_frame(int d0);
    for (int i = 0; i < 40 && done_cnt == d0; i++) step();
    check("done_pulses", done_cnt, d0 + 1);
    check("done_cycle", done_cyc, last_acc + P + 3);
    check("busy_after_done", int'(busy_o), 0);
    check("pending_strobes", exp_q.size(), 0);
    exp_frames++;
`ifdef MEDIAN_FRAME_CNT_EN
    check("frame_cnt", int'(frame_cnt_o), exp_frames);
`endif
  endtask

  task automatic run_frame(int pat, int gap, output int strobes, output int err_seen);
    int d0, s0;
    d0 = done_cnt; s0 = strobe_cnt; first_strobe = -1;
    err_seen = 0;
    fill_img(pat);
    start_frame();
    check("err_cleared_on_start", int'(err_o), 0);
    check("ready_in_fill", int'(ready_o), 1);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (gap != 0 && c == 0) begin step(); step(); end
        if (err_o) err_seen = 1;
        drive_pix(r, c);
      end
    finish_frame(d0);
    if (err_o) err_seen = 1;
    check("first_strobe_latency", first_strobe - acc18, 6);
    strobes = strobe_cnt - s0;
  endtask

  initial begin
    vec_t tbl[5];
    int strobes, err_seen, d0;
    tbl[0] = '{pat: 0, gap: 0, strobes: 24, err: 0};
    tbl[1] = '{pat: 1, gap: 0, strobes: 24, err: 0};
    tbl[2] = '{pat: 0, gap: 1, strobes: 24, err: 0};
    tbl[3] = '{pat: 2, gap: 0, strobes: 24, err: 0};
    tbl[4] = '{pat: 2, gap: 1, strobes: 24, err: 0};

    rst = 1'b1; start_i = 1'b0; pix_valid_i = 1'b0; pix_i = '0;
    step(); step(); step();
    check("rst_busy", int'(busy_o), 0);
    check("rst_ready", int'(ready_o), 0);
    check("rst_med_valid", int'(med_valid_o), 0);
    check("rst_done", int'(frame_done_o), 0);
    check("rst_err", int'(err_o), 0);
    check("rst_row0", int'(row0_o), 0);
    check("rst_row2", int'(row2_o), 0);
    check("rst_med", int'(med_o), 0);
`ifdef MEDIAN_FRAME_CNT_EN
    check("rst_frame_cnt", int'(frame_cnt_o), 0);
`endif
    rst = 1'b0;
    step();

    for (int i = 0; i < 5; i++) begin
      run_frame(tbl[i].pat, tbl[i].gap, strobes, err_seen);
      check("strobe_count", strobes, tbl[i].strobes);
      check("err_during_frame", err_seen, tbl[i].err);
      step();
    end

    // Mid-row gap at (r3,c4) aborts the frame; in-flight strobes still emerge.
    d0 = done_cnt;
    fill_img(0);
    start_frame();
    for (int k = 0; k < 28; k++) drive_pix(k / W, k % W);
    step();
    check("abort_err", int'(err_o), 1);
    check("abort_busy", int'(busy_o), 0);
    check("abort_ready", int'(ready_o), 0);
    for (int i = 0; i < 12; i++) step();
    check("abort_no_done", done_cnt, d0);
    check("abort_inflight_drained", exp_q.size(), 0);
    check("abort_err_sticky", int'(err_o), 1);
    run_frame(0, 0, strobes, err_seen);
    check("post_abort_strobes", strobes, 24);
    step();

    // Reset at pixel 30 discards everything in flight.
    fill_img(2);
    start_frame();
    for (int k = 0; k < 30; k++) drive_pix(k / W, k % W);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    check("midrst_busy", int'(busy_o), 0);
    check("midrst_ready", int'(ready_o), 0);
    check("midrst_med_valid", int'(med_valid_o), 0);
    check("midrst_row1", int'(row1_o), 0);
    for (int i = 0; i < 12; i++) step();
`ifdef MEDIAN_FRAME_CNT_EN
    check("midrst_frame_cnt", int'(frame_cnt_o), 0);
    exp_frames = 0;
`endif
    run_frame(2, 0, strobes, err_seen);
    check("post_rst_strobes", strobes, 24);
    run_frame(1, 1, strobes, err_seen);
    check("post_rst_strobes2", strobes, 24);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
